y86_cc_unit: RTL
================

# y86_cc_unit

Condition-code register and condition evaluator for the Y86 SEQ execute stage, sitting directly downstream of the ALU. It derives ZF/SF/OF from each OPq result and operands, and holds them in a 3-bit CC register. For jXX/cmovXX it evaluates the instruction's ifun against the held flags and delivers a registered Cnd to the fetch (PC select) and write-back (cmov) logic.

## Interface
- WIDTH, 64, operand/result width of the ALU (valA, valB, valE).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result valid this cycle.
- alufun  in  2  ALU operation: 0 add, 1 sub, 2 and, 3 xor.
- alu_a  in  WIDTH  aluA operand.
- alu_b  in  WIDTH  aluB operand.
- alu_y  in  WIDTH  ALU result valE. Sub is defined as alu_b − alu_a.
- set_cc  in  1  current instruction is OPq.
- stat_ok  in  1  instruction status is AOK. When 0, CC is not written.
- cond_valid  in  1  request a condition evaluation this cycle.
- ifun  in  4  condition code: 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g.
- cc  out  3  {ZF, SF, OF} register contents.
- cnd  out  1  registered condition result.
- cnd_valid  out  1  cnd is valid this cycle.
- bad_ifun  out  1  registered; the last request had ifun > 6.

## Operation
- Flag derivation is combinational from the inputs:
  - ZF = (alu_y == 0).
  - SF = alu_y[WIDTH-1].
  - OF for add = (a_msb == b_msb) & (y_msb != a_msb).
  - OF for sub = (a_msb != b_msb) & (y_msb != b_msb).
  - OF for and/xor = 0.
- CC write: cc ← {ZF, SF, OF} at the clock edge when alu_valid & set_cc & stat_ok. Otherwise cc holds.
- alu_valid without set_cc (e.g. address arithmetic) never changes cc.
- Condition evaluation uses S = SF^OF:
  - always → 1; le → S | ZF; l → S; e → ZF; ne → ~ZF; ge → ~S; g → ~S & ~ZF.
- ifun > 6 forces cnd = 0 and bad_ifun = 1.
- Flag source for evaluation is decided by CC_BYPASS_EN (see Configuration).
- cond_valid = 0: cnd_valid = 0 next cycle. cnd and bad_ifun hold their last values.
- Reset sets cc = 3'b100 (ZF=1, SF=0, OF=0), cnd = 0, cnd_valid = 0, bad_ifun = 0.
- rst takes priority over any simultaneous CC write or evaluation request in the same cycle.

## Timing
- CC update latency is 1 cycle: new flags are visible on cc the cycle after the qualifying edge.
- Cnd latency is 1 cycle: cnd/cnd_valid/bad_ifun are registered at the edge where cond_valid = 1.
- cnd_valid is a single-cycle pulse per request.
- Back-to-back requests produce back-to-back results, fully pipelined, with no stall.
- A CC write and a cond_valid in the same cycle: the source of the flags is decided by CC_BYPASS_EN.
- Reset mid-operation: a pending result is dropped, so cnd_valid = 0 the cycle after rst.
- No backpressure: consumers must sample cnd when cnd_valid = 1.

## Configuration
- CC_BYPASS_EN defined: a same-cycle CC write is forwarded, so evaluation uses the freshly derived flags. This is intended for pipelined reuse.
- CC_BYPASS_EN undefined: evaluation always uses the registered cc, which is the pre-update value. This is the SEQ behaviour.

## Test plan
- Reset, then evaluate ifun=3 (e) → cc=100, cnd=1 one cycle later; ifun=4 (ne) → cnd=0.
- add: a=0x7FFF_FFFF_FFFF_FFFF, b=1, y=0x8000_0000_0000_0000, set_cc=1 → cc=011; then ifun=2 (l) → cnd=0 and ifun=6 (g) → cnd=1.
- Sub case (status gating):
  - sub a=3, b=2, y=0xFFFF_FFFF_FFFF_FFFF → cc=010, ifun=1 (le) → cnd=1.
  - The same with stat_ok=0 → cc unchanged.
- Simultaneous sub a=5, b=5, y=0 with ifun=3, starting from cc=010:
  - Without CC_BYPASS_EN → cnd=0.
  - With CC_BYPASS_EN → cnd=1.
  - In both builds, cc=100 the next cycle.
- Edge cases:
  - ifun=9 → cnd=0, bad_ifun=1.
  - alu_valid=1 with set_cc=0, xor y=0 → cc unchanged.
  - rst asserted with cond_valid=1 → cnd_valid=0, cc=100.

Source files
------------

// File: rtl/y86_cc_unit.sv
// Y86 condition-code register and jXX/cmovXX condition evaluator.
// Define CC_BYPASS_EN to forward a same-cycle CC write into the evaluation.
module y86_cc_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [1:0]       alufun,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             set_cc,
    input  logic             stat_ok,
    input  logic             cond_valid,
    input  logic [3:0]       ifun,
    output logic [2:0]       cc,
    output logic             cnd,
    output logic             cnd_valid,
    output logic             bad_ifun
);

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } flags_t;

    flags_t new_flags;
    flags_t ev_flags;
    logic   cc_we;
    logic   a_msb, b_msb, y_msb;
    logic   s_bit;
    logic   cnd_next;

    assign a_msb = alu_a[WIDTH-1];
    assign b_msb = alu_b[WIDTH-1];
    assign y_msb = alu_y[WIDTH-1];
    assign cc_we = alu_valid & set_cc & stat_ok;

    always_comb begin
        new_flags.zf = (alu_y == '0);
        new_flags.sf = y_msb;
        unique case (alufun)
            ALU_ADD: new_flags.of = (a_msb == b_msb) & (y_msb != a_msb);
            // Sub computes alu_b - alu_a, so overflow is judged against b.
            ALU_SUB: new_flags.of = (a_msb != b_msb) & (y_msb != b_msb);
            default: new_flags.of = 1'b0;
        endcase
    end

`ifdef CC_BYPASS_EN
    assign ev_flags = cc_we ? new_flags : flags_t'(cc);
`else
    assign ev_flags = flags_t'(cc);
`endif

    assign s_bit = ev_flags.sf ^ ev_flags.of;

    always_comb begin
        cnd_next = 1'b0;
        unique case (ifun)
            4'd0:    cnd_next = 1'b1;
            4'd1:    cnd_next = s_bit | ev_flags.zf;
            4'd2:    cnd_next = s_bit;
            4'd3:    cnd_next = ev_flags.zf;
            4'd4:    cnd_next = ~ev_flags.zf;
            4'd5:    cnd_next = ~s_bit;
            4'd6:    cnd_next = ~s_bit & ~ev_flags.zf;
            default: cnd_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc        <= 3'b100;
            cnd       <= 1'b0;
            cnd_valid <= 1'b0;
            bad_ifun  <= 1'b0;
        end else begin
            if (cc_we)
                cc <= new_flags;
            cnd_valid <= cond_valid;
            if (cond_valid) begin
                cnd      <= cnd_next;
                bad_ifun <= (ifun > 4'd6);
            end
        end
    end

endmodule
